// File: rtl/pulse_gen_pkg.sv
// Shared types for the pulse generator bank: channel state and mode encodings.
package pulse_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: state, period counter, latched configuration and output decode.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = 5,
  parameter int unsigned DEFAULT_HIGH   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_high,
  input  logic             wr_oneshot,
  output logic             signal,
  output logic             period_end,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   per_q, per_d;
  logic [WIDTH-1:0]   high_q, high_d;
  logic               mode_q, mode_d;
  logic               last_c;
  logic               sig_d, pe_d, busy_d;

  // Next state, then outputs decoded from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    mode_d  = mode_q;
    last_c  = (per_q != '0) && (cnt_q == per_q - WIDTH'(1));

    if (wr) begin
      per_d   = wr_period;
      high_d  = wr_high;
      mode_d  = wr_oneshot;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((per_q != '0) && ((mode_q == MODE_CONT) || start)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (last_c) begin
            cnt_d = '0;
            if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
    sig_d  = busy_d && (cnt_d < high_d);
    pe_d   = busy_d && (per_d != '0) && (cnt_d == per_d - WIDTH'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      per_q      <= WIDTH'(DEFAULT_PERIOD);
      high_q     <= WIDTH'(DEFAULT_HIGH);
      mode_q     <= MODE_CONT;
      signal     <= 1'b0;
      period_end <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      high_q     <= high_d;
      mode_q     <= mode_d;
      signal     <= sig_d;
      period_end <= pe_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: rtl/pulse_generator_bank.sv
// Bank of independent pulse channels with a shared, channel-addressed config write port.
module pulse_generator_bank
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = 5,
  parameter int unsigned DEFAULT_HIGH   = 1,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] start,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic                cfg_oneshot,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] period_end,
  output logic [CHANNELS-1:0] busy
);

  // Out-of-range cfg_ch values match no channel, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_c;
    assign wr_c = cfg_we && (cfg_ch == CH_W'(i));

    pulse_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_HIGH   (DEFAULT_HIGH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[i]),
      .start      (start[i]),
      .wr         (wr_c),
      .wr_period  (cfg_period),
      .wr_high    (cfg_high),
      .wr_oneshot (cfg_oneshot),
      .signal     (signal[i]),
      .period_end (period_end[i]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_generator_bank.sv
// Randomized and directed checks of pulse_generator_bank against an elapsed-time model.
module tb_pulse_generator_bank;

  localparam int NCH  = 5;
  localparam int CH_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en, start;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [7:0]       cfg_period, cfg_high;
  logic             cfg_oneshot;
  logic [NCH-1:0]   signal, period_end, busy;

  pulse_generator_bank #(
    .CHANNELS(NCH), .WIDTH(8), .DEFAULT_PERIOD(5), .DEFAULT_HIGH(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
    .cfg_oneshot(cfg_oneshot), .signal(signal), .period_end(period_end), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_on = 1'b0;
  int   cyc = 0;

  // Model: a channel is active since cycle m_rs; phase is elapsed time mod P.
  logic m_act [NCH];
  int   m_rs  [NCH];
  int   m_p   [NCH];
  int   m_h   [NCH];
  logic m_os  [NCH];
  logic mr;

  function automatic logic m_running(input int ch, input int n);
    return m_act[ch] && (m_p[ch] != 0) && (!m_os[ch] || ((n - m_rs[ch]) < m_p[ch]));
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 1'b0; m_rs[c] = 0; m_p[c] = 5; m_h[c] = 1; m_os[c] = 1'b0;
    end
  endfunction

  task automatic m_expect(output logic [NCH-1:0] es, output logic [NCH-1:0] ep,
                          output logic [NCH-1:0] eb);
    int ph;
    es = '0; ep = '0; eb = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_running(c, cyc)) begin
        ph = (cyc - m_rs[c]) % m_p[c];
        eb[c] = 1'b1;
        es[c] = (ph < m_h[c]);
        ep[c] = (ph == m_p[c] - 1);
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model advance on each sampled edge.
  always @(posedge clk) begin
    if (chk_on && !reset) begin
      for (int c = 0; c < NCH; c++) begin
        mr = m_running(c, cyc);
        if (cfg_we && (int'(cfg_ch) == c)) begin
          m_p[c] = int'(cfg_period); m_h[c] = int'(cfg_high);
          m_os[c] = cfg_oneshot; m_act[c] = 1'b0;
        end else if (!en[c]) begin
          m_act[c] = 1'b0;
        end else if (!mr) begin
          if ((m_p[c] != 0) && (!m_os[c] || start[c])) begin
            m_act[c] = 1'b1; m_rs[c] = cyc + 1;
          end else begin
            m_act[c] = 1'b0;
          end
        end
      end
      cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [NCH-1:0] es, ep, eb;
      m_expect(es, ep, eb);
      check("signal", 16'(signal), 16'(es));
      check("period_end", 16'(period_end), 16'(ep));
      check("busy", 16'(busy), 16'(eb));
    end
  end

  task automatic cfg_write(input int ch, input int p, input int h, input logic os);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_period = 8'(p); cfg_high = 8'(h); cfg_oneshot = os;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pat_check(input string name, input int ch, input logic [15:0] ps,
                           input logic [15:0] pp, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({name, "_sig"}, 16'(signal[ch]), 16'(ps[k]));
      check({name, "_pe"}, 16'(period_end[ch]), 16'(pp[k]));
    end
  endtask

  task automatic window(input int ch, input int n, output int ns, output int np, output int nb);
    ns = 0; np = 0; nb = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ns += int'(signal[ch]); np += int'(period_end[ch]); nb += int'(busy[ch]);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_outputs", 16'({signal, period_end, busy}), 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ns, np, nb;
    int nb2;
    logic [5:0] acc;
    reset = 1'b1; en = '0; start = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_high = '0; cfg_oneshot = 1'b0;
    model_reset();
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 16'({signal, period_end, busy}), 16'h0);
    reset = 1'b0;

    // Legacy divide-by-5 default on ch0.
    en[0] = 1'b1;
    pat_check("t1_ch0", 0, 16'b0000100001, 16'b1000010000, 10);

    // ch1 P=4 H=2, then a mid-period rewrite to P=3.
    en[1] = 1'b1;
    cfg_write(1, 4, 2, 1'b0);
    pat_check("t2_p4", 1, 16'b00110011, 16'b10001000, 8);
    cfg_write(1, 3, 2, 1'b0);
    check("t2_gap_busy", 16'(busy[1]), 16'h0);
    pat_check("t2_p3", 1, 16'b011011, 16'b100100, 6);

    // ch2 one-shot P=6 H=3 with an ignored retrigger.
    en[2] = 1'b1;
    cfg_write(2, 6, 3, 1'b1);
    check("t3_idle", 16'(busy[2]), 16'h0);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    nb = 0; np = 0; acc = '0;
    for (int k = 0; k < 12; k++) begin
      nb += int'(busy[2]); np += int'(period_end[2]);
      if (k < 6) acc[k] = signal[2];
      start[2] = (k == 2);
      @(negedge clk);
    end
    start[2] = 1'b0;
    check("t3_busy_cycles", 16'(nb), 16'd6);
    check("t3_pe_count", 16'(np), 16'd1);
    check("t3_sig_pattern", 16'(acc), 16'b000111);

    // ch3 boundaries.
    en[3] = 1'b1;
    cfg_write(3, 0, 1, 1'b0);
    window(3, 6, ns, np, nb);
    check("t4_p0_all", 16'(ns + np + nb), 16'd0);
    cfg_write(3, 3, 5, 1'b0);
    window(3, 6, ns, np, nb);
    check("t4_h_ge_p_sig", 16'(ns), 16'd6);
    cfg_write(3, 1, 1, 1'b0);
    window(3, 5, ns, np, nb);
    check("t4_p1_pe", 16'(np), 16'd5);
    cfg_write(3, 4, 0, 1'b0);
    window(3, 8, ns, np, nb);
    check("t4_h0_sig", 16'(ns), 16'd0);
    check("t4_h0_busy", 16'(nb), 16'd8);

    // Async reset mid-period, restart with defaults.
    async_reset();
    pat_check("t5_ch0", 0, 16'b0000100001, 16'b1000010000, 10);

    // Same-cycle write plus starts; out-of-range writes dropped.
    en[4] = 1'b1;
    repeat (3) @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd3; cfg_high = 8'd1; cfg_oneshot = 1'b0;
    start[1:0] = 2'b11;
    @(negedge clk);
    cfg_we = 1'b0; start[1:0] = 2'b00;
    check("t6_ch0_idle", 16'(busy[0]), 16'h0);
    check("t6_ch1_run", 16'(busy[1]), 16'h1);
    pat_check("t6_ch0", 0, 16'b001001, 16'b100100, 6);
    cfg_write(5, 2, 2, 1'b1);
    check("t6_oob5_busy", 16'(busy), 16'h1f);
    cfg_write(7, 0, 0, 1'b1);
    check("t6_oob7_busy", 16'(busy), 16'h1f);
    window(0, 6, ns, np, nb2);
    check("t6_ch0_kept_p3", 16'(np), 16'd2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en          = NCH'($urandom) | NCH'($urandom) | NCH'($urandom);
      start       = NCH'($urandom) & NCH'($urandom);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_ch      = 3'($urandom_range(0, 7));
      cfg_period  = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) cfg_period = 8'($urandom);
      cfg_high    = 8'($urandom_range(0, 11));
      cfg_oneshot = 1'($urandom);
      if ($urandom_range(0, 599) == 0) async_reset();
      else @(negedge clk);
    end
    cfg_we = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_generator_bank.md
Name: pulse_generator_bank

Overview:
Parametrised, multi-channel successor to the fixed divide-by-5 pulse generator. Each channel produces a periodic or one-shot pulse train with a runtime-programmable period and high time. Per-channel period-end strobes are provided for downstream sequencing. Sits between the system clock and any logic needing timed enables or strobes. Reset defaults reproduce the legacy one-pulse-every-5-cycles behaviour on every channel.

Parameters:
CHANNELS, 4, number of independent channels (1..16)
WIDTH, 8, counter/config width in bits; max period 2^WIDTH-1
DEFAULT_PERIOD, 5, period loaded at reset (must be < 2^WIDTH)
DEFAULT_HIGH, 1, high time loaded at reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
en  in  CHANNELS  per-channel enable, level
start  in  CHANNELS  per-channel one-shot trigger, sampled per cycle
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of write
cfg_period  in  WIDTH  period P in cycles
cfg_high  in  WIDTH  high time H in cycles
cfg_oneshot  in  1  0 = continuous, 1 = one-shot
signal  out  CHANNELS  pulse outputs
period_end  out  CHANNELS  1-cycle strobe on last cycle of each period
busy  out  CHANNELS  channel in RUN state

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Assertion immediately forces all channels to IDLE, cnt=0, P=DEFAULT_PERIOD, H=DEFAULT_HIGH, continuous mode. While reset is high, signal/period_end/busy = 0. Release is sampled at the next rising edge.
- Per-channel state: IDLE, RUN. Each channel has a WIDTH-bit counter cnt.
- Outputs are Moore-decoded from registered state only; no combinational input-to-output path:
  - signal = RUN && cnt < H
  - period_end = RUN && cnt == P-1
  - busy = RUN
- Continuous mode:
  - IDLE->RUN at the edge where en=1 is sampled; cnt=0 after that edge.
  - In RUN: cnt increments each edge and wraps P-1 -> 0. The channel stays in RUN.
  - en=0 sampled in either mode: next edge forces IDLE, cnt=0, so outputs are low the following cycle.
- One-shot mode:
  - IDLE->RUN at an edge with start=1 and en=1; cnt=0.
  - At the edge where cnt==P-1: RUN->IDLE, cnt=0. period_end is high during that last cycle.
  - start while in RUN is ignored (no retrigger).
  - start is ignored in continuous mode.
- Boundaries:
  - P=0: channel never leaves IDLE; all outputs stay 0.
  - H=0: signal is never high.
  - H>=P (P>0): signal is constantly high in RUN.
  - P=1: period_end is high every RUN cycle.
- Config write (cfg_we=1 at an edge):
  - Latches P/H/mode into channel cfg_ch and forces that channel to IDLE, cnt=0.
  - A continuous channel with en=1 re-enters RUN on the following edge (1 cycle gap).
  - The write takes priority over a start or en on the same channel in the same cycle.
  - cfg_ch >= CHANNELS: write is discarded.
- Channels are fully independent. Simultaneous starts, writes, and wraps on different channels never interact.
- Arithmetic: cnt, P, H are unsigned WIDTH-bit values. The wrap compare is cnt==P-1, evaluated only when P>0, so no underflow path exists.

Decomposition:
- Shared package pulse_gen_pkg: state enum (ST_IDLE, ST_RUN), mode constants (MODE_CONT=0, MODE_ONESHOT=1).
- Sub-module pulse_channel holds the per-channel state, counter, config registers, and output decode.
- Top-level pulse_generator_bank holds generate-loop instantiation and the cfg_ch decode/write fan-out.

Test Plan:
1. Reset then en[0]=1, no writes -> signal[0] high 1 cycle in every 5 (cycles 0,5,10…). period_end[0] at cycles 4,9,14.
2. Write ch1 P=4 H=2 continuous, en[1]=1 -> signal[1] pattern 1100 repeating. period_end[1] every 4th cycle. Write P=3 mid-period -> 1 idle cycle, then 110 repeating.
3. Write ch2 one-shot P=6 H=3, start[2] pulse -> busy 6 cycles, signal 111000, single period_end, return to IDLE. Second start during busy -> no extension.
4. Boundaries on ch3:
   - P=0 -> all outputs 0 with en=1.
   - P=3 H=5 -> signal constant 1.
   - P=1 -> period_end constant 1.
   - H=0 -> signal 0.
5. Assert reset asynchronously mid-period (between edges) -> outputs drop immediately. After release with en held, pattern restarts from cnt=0 with default P=5 H=1.
6. Same cycle: cfg_we to ch0 plus start/en toggles on ch0 and ch1 -> ch0 takes config and goes IDLE. ch1 behaves unaffected. cfg_ch=CHANNELS write is ignored (CHANNELS<2^width).
